mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of register/memory data.
REQ-002 Parameter ADDR_WIDTH, default 32, width of byte address.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 ex_valid  input  1  EX/MEM slot holds a live instruction.
REQ-006 mem_read / mem_write  input  1 each  load / store instruction.
REQ-007 funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 addr  input  ADDR_WIDTH  byte address from ALU.
REQ-009 store_data  input  DATA_WIDTH  rs2 value for stores.
REQ-010 alu_result / memtoreg_in / regwrite_in / rd_in  input  DATA_WIDTH/1/1/5  fields forwarded toward write-back.
REQ-011 dmem_req / dmem_we  output  1 each  memory request / write strobe.
REQ-012 dmem_addr  output  ADDR_WIDTH  word-aligned address (addr[1:0] forced 00).
REQ-013 dmem_wdata / dmem_be  output  DATA_WIDTH / 4  lane-positioned store data, byte enables.
REQ-014 dmem_rdata / dmem_ready  input  DATA_WIDTH / 1  read word; one-cycle completion pulse.
REQ-015 stall  output  1  holds upstream stages; inputs stay stable while high.
REQ-016 wb_valid / memtoreg / regwrite / rd  output  1/1/1/5  registered MEM/WB control.
REQ-017 data_i / wb_data  output  DATA_WIDTH each  aligned, extended load data; registered alu_result.
REQ-018 misalign  output  1  misaligned-access flag (see Configuration).

Function
REQ-019 FSM states IDLE, BUSY; IDLE->BUSY when ex_valid & (mem_read|mem_write) & access permitted; BUSY->IDLE on dmem_ready.
REQ-020 On IDLE->BUSY edge, block SHALL latch addr, funct3, store_data, read/write, alu_result, rd, regwrite_in, memtoreg_in.
REQ-021 dmem_req = (state==BUSY); dmem_we, dmem_addr, dmem_wdata, dmem_be driven from latched fields, held constant until dmem_ready.
REQ-022 stall = (IDLE & ex_valid & mem op & permitted) | (BUSY & !dmem_ready); stall low in the dmem_ready cycle.
REQ-023 Store byte: be = 0001<<addr[1:0], byte replicated on all lanes; half: be = 0011<<{addr[1],0}, half replicated; word: be = 1111.
REQ-024 Load: word shifted right by 8*addr[1:0], then sign-extended (B,H) or zero-extended (BU,HU); W unchanged.
REQ-025 Load/store latency: wb_valid asserts the edge after dmem_ready; minimum 2 cycles from instruction arrival.
REQ-026 Non-memory instruction in IDLE: MEM/WB registers load on next edge, wb_valid=1, data_i=0, stall=0 (1-cycle latency).
REQ-027 Store completes with wb_valid=1, regwrite=0 regardless of regwrite_in.
REQ-028 ex_valid=0 in IDLE: wb_valid=0 next edge, regwrite=0.
REQ-029 dmem_ready while IDLE SHALL be ignored.
REQ-030 Back-to-back memory ops: new op starts BUSY on the edge after the completing op's wb_valid edge at earliest; no request gap beyond one IDLE cycle.

Reset
REQ-031 rst SHALL force state=IDLE and clear dmem_req, dmem_we, dmem_be, stall, wb_valid, regwrite, memtoreg, misalign, rd, data_i, wb_data to 0.
REQ-032 rst asserted in BUSY SHALL abandon the request; a dmem_ready arriving after reset is ignored.

Configuration
REQ-033 Macro MEM_MISALIGN_TRAP_EN defined: H with addr[0]=1 or W with addr[1:0]!=00 is not permitted -> no memory request, next edge wb_valid=1, regwrite=0, misalign=1 for one cycle.
REQ-034 MEM_MISALIGN_TRAP_EN undefined: misalign tied 0; access proceeds with dmem_addr aligned and lanes chosen per REQ-023/024 using addr bits as given.

Verification
REQ-035 LB at addr 0x103, dmem_rdata=0x80FF_1234, ready after 3 cycles -> data_i=0xFFFF_FF80, stall high 3 cycles, wb_valid 1 cycle.
REQ-036 SH data 0x0000_ABCD at 0x202 -> dmem_addr=0x200, be=1100, wdata=0xABCD_ABCD, regwrite=0.
REQ-037 ADD result 0x55 (no mem op) -> wb_data=0x55, wb_valid next edge, stall never high.
REQ-038 LW at 0x101 with macro -> no dmem_req, misalign=1, regwrite=0; without macro -> dmem_addr=0x100, req issued.
REQ-039 rst asserted during BUSY, then dmem_ready -> dmem_req drops same edge, all outputs 0, no wb_valid.
REQ-040 LHU at 0x002, rdata=0x8001_0000, then immediate LW -> data_i=0x0000_8001, second request follows one IDLE cycle.

Source files
------------

// File: rtl/mem_access.sv
// Purpose: MEM stage of a 5-stage pipeline; issues one data-memory access per load/store, aligns load data, registers MEM/WB fields.
// Latency: non-memory ops 1 cycle; loads/stores 2 cycles minimum (request cycle + edge after dmem_ready).
// Backpressure: stall held from op arrival until the dmem_ready cycle; upstream inputs must stay stable while stall is high.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of issuing them.
module mem_access #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] store_data,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  memtoreg_in,
    input  logic                  regwrite_in,
    input  logic [4:0]            rd_in,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [3:0]            dmem_be,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    input  logic                  dmem_ready,
    output logic                  stall,
    output logic                  wb_valid,
    output logic                  memtoreg,
    output logic                  regwrite,
    output logic [4:0]            rd,
    output logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  misalign
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t state, state_nxt;

    // Fields captured when the access is launched; they drive the memory port for its whole life.
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [2:0]            lat_f3;
    logic [DATA_WIDTH-1:0] lat_sdata;
    logic                  lat_read;
    logic                  lat_write;
    logic [DATA_WIDTH-1:0] lat_alu;
    logic [4:0]            lat_rd;
    logic                  lat_rw;
    logic                  lat_m2r;

    logic                  mem_op;
    logic                  access_ok;
    logic                  start;
    logic                  trap;
    logic [3:0]            be_calc;
    logic [DATA_WIDTH-1:0] wdata_calc;
    logic [4:0]            shamt;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] load_val;

    assign mem_op = mem_read | mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
    // Halfwords must be 2-byte aligned, words 4-byte aligned; anything else is refused.
    assign access_ok = !(((funct3[1:0] == 2'b01) && addr[0]) ||
                         ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)));
`else
    // Every access is issued; lane selection uses the low address bits as given.
    assign access_ok = 1'b1;
`endif

    assign start = (state == IDLE) && ex_valid && mem_op && access_ok;
    assign trap  = (state == IDLE) && ex_valid && mem_op && !access_ok;

    // State register: reset abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: launch on a permitted memory op, return on the completion pulse.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)      state_nxt = BUSY;
            BUSY:    if (dmem_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Outputs: memory port active only in BUSY; stall covers the launch cycle and the wait.
    always_comb begin
        dmem_req   = (state == BUSY);
        dmem_we    = (state == BUSY) && lat_write;
        dmem_be    = (state == BUSY) ? be_calc : 4'b0000;
        dmem_wdata = (state == BUSY) ? wdata_calc : '0;
        dmem_addr  = {lat_addr[ADDR_WIDTH-1:2], 2'b00};
        stall      = !rst && (start || ((state == BUSY) && !dmem_ready));
    end

    // Launch capture: snapshot the instruction fields on the IDLE->BUSY edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_addr  <= '0;
            lat_f3    <= '0;
            lat_sdata <= '0;
            lat_read  <= 1'b0;
            lat_write <= 1'b0;
            lat_alu   <= '0;
            lat_rd    <= '0;
            lat_rw    <= 1'b0;
            lat_m2r   <= 1'b0;
        end else if (start) begin
            lat_addr  <= addr;
            lat_f3    <= funct3;
            lat_sdata <= store_data;
            lat_read  <= mem_read;
            lat_write <= mem_write;
            lat_alu   <= alu_result;
            lat_rd    <= rd_in;
            lat_rw    <= regwrite_in;
            lat_m2r   <= memtoreg_in;
        end
    end

    // Store lanes: sub-word data is replicated so the enabled lane always carries it.
    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = lat_sdata;
        case (lat_f3[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << lat_addr[1:0];
                wdata_calc = {(DATA_WIDTH/8){lat_sdata[7:0]}};
            end
            2'b01: begin
                be_calc    = 4'b0011 << {lat_addr[1], 1'b0};
                wdata_calc = {(DATA_WIDTH/16){lat_sdata[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = lat_sdata;
            end
        endcase
    end

    // Load alignment: bring the addressed byte/half to bit 0, then extend; words pass through.
    always_comb begin
        shamt   = {lat_addr[1:0], 3'b000};
        shifted = dmem_rdata >> shamt;
        case (lat_f3)
            F3_B:    load_val = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            F3_H:    load_val = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            F3_BU:   load_val = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
            F3_HU:   load_val = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            default: load_val = dmem_rdata;
        endcase
    end

    // MEM/WB register: completions from BUSY, pass-through or trapped ops from IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            regwrite <= 1'b0;
            memtoreg <= 1'b0;
            rd       <= '0;
            data_i   <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= 1'b0;
            regwrite <= 1'b0;
            if (state == BUSY) begin
                if (dmem_ready) begin
                    wb_valid <= 1'b1;
                    regwrite <= lat_rw && !lat_write;
                    memtoreg <= lat_m2r;
                    rd       <= lat_rd;
                    wb_data  <= lat_alu;
                    data_i   <= lat_read ? load_val : '0;
                end
            end else if (ex_valid && !start) begin
                wb_valid <= 1'b1;
                regwrite <= regwrite_in && !trap;
                memtoreg <= memtoreg_in;
                rd       <= rd_in;
                wb_data  <= alu_result;
                data_i   <= '0;
            end
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // Misalign flag: one-cycle pulse alongside the trapped op's write-back slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign <= 1'b0;
        end else begin
            misalign <= trap;
        end
    end
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Purpose: directed self-checking bench for mem_access with a write-back scoreboard.
// Latency: expectations pushed when an op is driven, popped when wb_valid is seen.
// Backpressure: bench plays the memory, holding inputs while stall is high.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] alu_result;
    logic        memtoreg_in;
    logic        regwrite_in;
    logic [4:0]  rd_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        stall;
    logic        wb_valid;
    logic        memtoreg;
    logic        regwrite;
    logic [4:0]  rd;
    logic [31:0] data_i;
    logic [31:0] wb_data;
    logic        misalign;

    typedef struct {
        logic [31:0] data_i;
        logic [31:0] wb_data;
        logic [31:0] rd;
        logic [31:0] regwrite;
        logic [31:0] memtoreg;
        logic [31:0] misalign;
    } wb_t;

    wb_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  stall_cnt;

    mem_access dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .addr(addr), .store_data(store_data), .alu_result(alu_result),
        .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in), .rd_in(rd_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .stall(stall),
        .wb_valid(wb_valid), .memtoreg(memtoreg), .regwrite(regwrite), .rd(rd),
        .data_i(data_i), .wb_data(wb_data), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write-back slot must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected_valid", 32'(wb_valid), 32'd0);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                chk("wb_data_i",   data_i,          e.data_i);
                chk("wb_wb_data",  wb_data,         e.wb_data);
                chk("wb_rd",       32'(rd),         e.rd);
                chk("wb_regwrite", 32'(regwrite),   e.regwrite);
                chk("wb_memtoreg", 32'(memtoreg),   e.memtoreg);
                chk("wb_misalign", 32'(misalign),   e.misalign);
            end
        end
    end

    task automatic drive_idle();
        ex_valid    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        regwrite_in = 1'b0;
        memtoreg_in = 1'b0;
    endtask

    task automatic push_exp(input logic [31:0] di, input logic [31:0] wd, input logic [4:0] dst,
                            input logic rw, input logic m2r, input logic mis);
        wb_t e;
        e.data_i   = di;
        e.wb_data  = wd;
        e.rd       = 32'(dst);
        e.regwrite = 32'(rw);
        e.memtoreg = 32'(m2r);
        e.misalign = 32'(mis);
        exp_q.push_back(e);
    endtask

    // Non-memory op (or bubble when vld=0); called at a negedge in IDLE.
    task automatic alu_op(input logic vld, input logic [31:0] res, input logic [4:0] dst, input logic rw);
        chk("alu_req_idle", 32'(dmem_req), 32'd0);
        ex_valid = vld; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b010;
        addr = res; alu_result = res; rd_in = dst; regwrite_in = rw; memtoreg_in = 1'b0;
        if (vld) push_exp(32'd0, res, dst, rw, 1'b0, 1'b0);
        #1 chk("alu_stall", 32'(stall), 32'd0);
        @(negedge clk);
        if (!vld) begin
            chk("bubble_wb_valid", 32'(wb_valid), 32'd0);
            chk("bubble_regwrite", 32'(regwrite), 32'd0);
        end
        drive_idle();
    endtask

    // Load/store; memory answers after 'extra' waiting BUSY cycles. Ends at the write-back negedge.
    task automatic mem_op(input string tag, input logic rd_op, input logic wr_op, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [4:0] dst,
                          input logic rw, input logic m2r, input logic [31:0] rdata, input int extra,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_data,
                          output int stalls);
        chk({tag, "_req_idle"}, 32'(dmem_req), 32'd0);
        ex_valid = 1'b1; mem_read = rd_op; mem_write = wr_op; funct3 = f3; addr = a;
        store_data = sd; alu_result = a; rd_in = dst; regwrite_in = rw; memtoreg_in = m2r;
        push_exp(rd_op ? exp_data : 32'd0, a, dst, rw && rd_op && !wr_op, m2r, 1'b0);
        #1 stalls = stall ? 1 : 0;
        @(negedge clk);
        chk({tag, "_req"},  32'(dmem_req), 32'd1);
        chk({tag, "_addr"}, dmem_addr, exp_addr);
        chk({tag, "_we"},   32'(dmem_we), 32'(wr_op));
        if (wr_op) begin
            chk({tag, "_be"},    32'(dmem_be), 32'(exp_be));
            chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
        end
        for (int i = 0; i < extra; i++) begin
            if (stall) stalls++;
            @(negedge clk);
            chk({tag, "_req_held"}, 32'(dmem_req), 32'd1);
        end
        dmem_ready = 1'b1;
        dmem_rdata = rdata;
        #1 chk({tag, "_stall_ready"}, 32'(stall), 32'd0);
        @(negedge clk);
        dmem_ready = 1'b0;
        drive_idle();
    endtask

    initial begin
        rst = 1'b1; store_data = '0; funct3 = '0; addr = '0; alu_result = '0; rd_in = '0;
        dmem_rdata = '0; dmem_ready = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_req",      32'(dmem_req), 32'd0);
        chk("rst_we",       32'(dmem_we),  32'd0);
        chk("rst_be",       32'(dmem_be),  32'd0);
        chk("rst_stall",    32'(stall),    32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_regwrite", 32'(regwrite), 32'd0);
        chk("rst_memtoreg", 32'(memtoreg), 32'd0);
        chk("rst_misalign", 32'(misalign), 32'd0);
        chk("rst_rd",       32'(rd),       32'd0);
        chk("rst_data_i",   data_i,        32'd0);
        chk("rst_wb_data",  wb_data,       32'd0);
        rst = 1'b0;

        // ADD result 0x55, then a bubble with regwrite_in high
        alu_op(1'b1, 32'h55, 5'd3, 1'b1);
        alu_op(1'b0, 32'h77, 5'd4, 1'b1);

        // LB 0x103, ready on the fourth cycle after arrival
        mem_op("lb", 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 5'd5, 1'b1, 1'b1, 32'h80FF_1234, 2,
               32'h100, 4'b0000, 32'h0, 32'hFFFF_FF80, stall_cnt);
        chk("lb_stall_cycles", 32'(stall_cnt), 32'd3);
        chk("lb_wb_valid_pulse", 32'(wb_valid), 32'd1);
        @(negedge clk);
        chk("lb_wb_valid_drop", 32'(wb_valid), 32'd0);

        // SH 0xABCD at 0x202 with regwrite_in high
        mem_op("sh", 1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 5'd6, 1'b1, 1'b0, 32'h0, 0,
               32'h200, 4'b1100, 32'hABCD_ABCD, 32'h0, stall_cnt);

        // SB 0x5A at 0x001, minimum latency
        mem_op("sb", 1'b0, 1'b1, 3'b000, 32'h001, 32'h1234_565A, 5'd7, 1'b0, 1'b0, 32'h0, 0,
               32'h000, 4'b0010, 32'h5A5A_5A5A, 32'h0, stall_cnt);
        chk("sb_stall_cycles", 32'(stall_cnt), 32'd1);

        // SW, LBU and LH
        mem_op("sw", 1'b0, 1'b1, 3'b010, 32'h008, 32'hCAFE_F00D, 5'd8, 1'b1, 1'b0, 32'h0, 1,
               32'h008, 4'b1111, 32'hCAFE_F00D, 32'h0, stall_cnt);
        mem_op("lbu", 1'b1, 1'b0, 3'b100, 32'h002, 32'h0, 5'd9, 1'b1, 1'b1, 32'h12C3_4567, 0,
               32'h000, 4'b0000, 32'h0, 32'h0000_00C3, stall_cnt);
        mem_op("lh", 1'b1, 1'b0, 3'b001, 32'h002, 32'h0, 5'd10, 1'b1, 1'b1, 32'h8001_0000, 1,
               32'h000, 4'b0000, 32'h0, 32'hFFFF_8001, stall_cnt);

        // LW at 0x101
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_req_idle", 32'(dmem_req), 32'd0);
        ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h101;
        alu_result = 32'h101; rd_in = 5'd11; regwrite_in = 1'b1; memtoreg_in = 1'b0;
        push_exp(32'd0, 32'h101, 5'd11, 1'b0, 1'b0, 1'b1);
        #1 chk("mis_stall", 32'(stall), 32'd0);
        @(negedge clk);
        chk("mis_req", 32'(dmem_req), 32'd0);
        drive_idle();
        @(negedge clk);
        chk("mis_pulse_drop", 32'(misalign), 32'd0);
`else
        mem_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 5'd11, 1'b1, 1'b1, 32'h1122_3344, 0,
               32'h100, 4'b0000, 32'h0, 32'h1122_3344, stall_cnt);
        chk("lw_mis_flag", 32'(misalign), 32'd0);
`endif

        // LHU then an immediate LW: one IDLE cycle between requests
        mem_op("lhu", 1'b1, 1'b0, 3'b101, 32'h002, 32'h0, 5'd12, 1'b1, 1'b1, 32'h8001_0000, 0,
               32'h000, 4'b0000, 32'h0, 32'h0000_8001, stall_cnt);
        mem_op("lw_b2b", 1'b1, 1'b0, 3'b010, 32'h004, 32'h0, 5'd13, 1'b1, 1'b1, 32'hDEAD_BEEF, 0,
               32'h004, 4'b0000, 32'h0, 32'hDEAD_BEEF, stall_cnt);

        // Reset while BUSY, then a late dmem_ready
        chk("rb_req_idle", 32'(dmem_req), 32'd0);
        ex_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h010;
        alu_result = 32'h010; rd_in = 5'd14; regwrite_in = 1'b1; memtoreg_in = 1'b1;
        @(negedge clk);
        chk("rb_req_busy", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        chk("rb_req",      32'(dmem_req), 32'd0);
        chk("rb_be",       32'(dmem_be),  32'd0);
        chk("rb_stall",    32'(stall),    32'd0);
        chk("rb_wb_valid", 32'(wb_valid), 32'd0);
        chk("rb_regwrite", 32'(regwrite), 32'd0);
        chk("rb_rd",       32'(rd),       32'd0);
        chk("rb_data_i",   data_i,        32'd0);
        chk("rb_wb_data",  wb_data,       32'd0);
        rst = 1'b0;
        dmem_ready = 1'b1;
        dmem_rdata = 32'h5555_AAAA;
        #1 chk("rb_late_stall", 32'(stall), 32'd0);
        @(negedge clk);
        dmem_ready = 1'b0;
        chk("rb_late_wb_valid", 32'(wb_valid), 32'd0);
        chk("rb_late_req",      32'(dmem_req), 32'd0);

        // Recovery after reset
        alu_op(1'b1, 32'hA5A5_0001, 5'd15, 1'b1);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
